// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory stages, decode and the register file write port.
// Carries both writeback request channels, scoreboard allocation, busy bits and the registered write.
// slave = arbiter side, master = producer/consumer side. Forwarding signals exist only with REGFILE_BYPASS_EN.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int DATA_W   = 32
);
  logic                wb_hold;
  logic                ch0_valid;
  logic [REG_AW-1:0]   ch0_num;
  logic [DATA_W-1:0]   ch0_data;
  logic                ch0_ready;
  logic                ch1_valid;
  logic [REG_AW-1:0]   ch1_num;
  logic [DATA_W-1:0]   ch1_data;
  logic                ch1_ready;
  logic                alloc_we;
  logic [REG_AW-1:0]   alloc_num;
  logic [NUM_REGS-1:0] busy;
  logic                reg_we;
  logic [REG_AW-1:0]   dstreg_num;
  logic [DATA_W-1:0]   dstreg_data;
`ifdef REGFILE_BYPASS_EN
  logic [REG_AW-1:0]   rs1_num;
  logic [REG_AW-1:0]   rs2_num;
  logic                rs1_fwd;
  logic                rs2_fwd;
  logic [DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]   rs2_data;
`endif

  modport slave (
    input  wb_hold, ch0_valid, ch0_num, ch0_data, ch1_valid, ch1_num, ch1_data,
    input  alloc_we, alloc_num,
`ifdef REGFILE_BYPASS_EN
    input  rs1_num, rs2_num,
    output rs1_fwd, rs2_fwd, rs1_data, rs2_data,
`endif
    output ch0_ready, ch1_ready, busy, reg_we, dstreg_num, dstreg_data
  );

  modport master (
    output wb_hold, ch0_valid, ch0_num, ch0_data, ch1_valid, ch1_num, ch1_data,
    output alloc_we, alloc_num,
`ifdef REGFILE_BYPASS_EN
    output rs1_num, rs2_num,
    input  rs1_fwd, rs2_fwd, rs1_data, rs2_data,
`endif
    input  ch0_ready, ch1_ready, busy, reg_we, dstreg_num, dstreg_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (ch0) and LSU (ch1), plus RAW scoreboard.
// Latency: 1 cycle from a transfer (valid & ready) to reg_we/dstreg_num/dstreg_data.
// Backpressure: ready is combinational; loser or wb_hold stalls the channel; x0 requests always accepted.
// Ports: clk, rst (sync active-low), bus (regfile_wb_arbiter_if.slave): ch0/ch1 valid/num/data/ready,
//        wb_hold, alloc_we/alloc_num, busy, reg_we/dstreg_num/dstreg_data.
// Optional REGFILE_BYPASS_EN: rs1/rs2 forwarding from the registered write; busy clears at the transfer edge.
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int DATA_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  typedef enum logic {PRI0, PRI1} pri_t;

  pri_t                pri_q, pri_d;
  logic                req0, req1;
  logic                grant0, grant1;
  logic                reg_we_q;
  logic [REG_AW-1:0]   num_q;
  logic [DATA_W-1:0]   data_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // A real request needs a nonzero destination; x0 requests never compete for the port.
  assign req0 = rst && !bus.wb_hold && bus.ch0_valid && (bus.ch0_num != '0);
  assign req1 = rst && !bus.wb_hold && bus.ch1_valid && (bus.ch1_num != '0);

  always_comb begin
    pri_d  = pri_q;
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (pri_q)
      PRI0: begin
        if (req0)      begin grant0 = 1'b1; pri_d = PRI1; end
        else if (req1) begin grant1 = 1'b1; pri_d = PRI0; end
      end
      default: begin
        if (req1)      begin grant1 = 1'b1; pri_d = PRI0; end
        else if (req0) begin grant0 = 1'b1; pri_d = PRI1; end
      end
    endcase
  end

  // x0 writes are swallowed immediately, even alongside the other channel's grant.
  assign bus.ch0_ready = grant0 || (rst && bus.ch0_valid && (bus.ch0_num == '0));
  assign bus.ch1_ready = grant1 || (rst && bus.ch1_valid && (bus.ch1_num == '0));

  always_comb begin
    busy_d = busy_q;
`ifdef REGFILE_BYPASS_EN
    // Consumers pick the value off the forward path, so release at the transfer edge.
    if (grant0) busy_d[bus.ch0_num] = 1'b0;
    if (grant1) busy_d[bus.ch1_num] = 1'b0;
`else
    if (reg_we_q) busy_d[num_q] = 1'b0;
`endif
    // Set after clear: a newer in-flight writer keeps the register pending.
    if (bus.alloc_we) busy_d[bus.alloc_num] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pri_q    <= PRI0;
      reg_we_q <= 1'b0;
      num_q    <= '0;
      data_q   <= '0;
      busy_q   <= '0;
    end else begin
      pri_q    <= pri_d;
      reg_we_q <= grant0 || grant1;
      busy_q   <= busy_d;
      if (grant0) begin
        num_q  <= bus.ch0_num;
        data_q <= bus.ch0_data;
      end else if (grant1) begin
        num_q  <= bus.ch1_num;
        data_q <= bus.ch1_data;
      end
    end
  end

  assign bus.reg_we      = reg_we_q;
  assign bus.dstreg_num  = num_q;
  assign bus.dstreg_data = data_q;
  assign bus.busy        = busy_q;

`ifdef REGFILE_BYPASS_EN
  assign bus.rs1_fwd  = reg_we_q && (num_q == bus.rs1_num) && (bus.rs1_num != '0);
  assign bus.rs2_fwd  = reg_we_q && (num_q == bus.rs2_num) && (bus.rs2_num != '0);
  assign bus.rs1_data = bus.rs1_fwd ? data_q : '0;
  assign bus.rs2_data = bus.rs2_fwd ? data_q : '0;
`endif
endmodule
